// File: rtl/regfile_writeback_arbiter.sv
// regfile_writeback_arbiter: merges pipeline writeback and long-latency results into one RF write port
module regfile_writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int AW         = 5,
    parameter int LL_DEPTH   = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            pipe_we,
    input  logic [AW-1:0]   pipe_waddr,
    input  logic [XLEN-1:0] pipe_wdata,
    input  logic            ll_issue_valid,
    input  logic [AW-1:0]   ll_issue_rd,
    input  logic            ll_valid,
    output logic            ll_ready,
    input  logic [AW-1:0]   ll_waddr,
    input  logic [XLEN-1:0] ll_wdata,
    output logic            rf_we,
    output logic [AW-1:0]   rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    input  logic [AW-1:0]   q_addr1,
    input  logic [AW-1:0]   q_addr2,
    output logic            q_busy1,
    output logic            q_busy2,
    output logic            pipe_hold
);
    localparam int PW = $clog2(LL_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [AW+XLEN-1:0] mem [LL_DEPTH];
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      count, count_nxt;
    logic [SW-1:0]      starve_cnt, starve_nxt;
    logic [2**AW-1:0]   busy, busy_nxt;
    logic               pipe_wr, push, pop;
    logic [AW-1:0]      head_addr;
    logic [XLEN-1:0]    head_data;

    assign ll_ready  = count < CW'(LL_DEPTH);
    assign push      = ll_valid && ll_ready;
    assign pipe_wr   = pipe_we && (pipe_waddr != '0);
    assign pop       = !pipe_wr && (count != '0);
    assign head_addr = mem[rd_ptr][AW+XLEN-1:XLEN];
    assign head_data = mem[rd_ptr][XLEN-1:0];
    assign q_busy1   = (q_addr1 != '0) && busy[q_addr1];
    assign q_busy2   = (q_addr2 != '0) && busy[q_addr2];
    assign count_nxt = count + CW'(push) - CW'(pop);

    // Scoreboard update: a drain clears its rd first so a same-cycle issue to that rd wins
    always_comb begin
        busy_nxt = busy;
        if (pop) busy_nxt[head_addr] = 1'b0;
        if (ll_issue_valid && ll_issue_rd != '0) busy_nxt[ll_issue_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    // Starvation counter: grows only while a pipe write blocks a non-empty FIFO
    always_comb begin
        starve_nxt = (pop || count == '0) ? '0 :
                     (starve_cnt >= SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
    end

    // FIFO storage needs no reset; pointers and count define validity
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= {ll_waddr, ll_wdata};
    end

    // FIFO pointers, scoreboard and starvation state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            busy       <= '0;
            starve_cnt <= '0;
            pipe_hold  <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count      <= count_nxt;
            busy       <= busy_nxt;
            starve_cnt <= starve_nxt;
            pipe_hold  <= starve_nxt >= SW'(STARVE_MAX);
        end
    end

    // Registered RF write port: pipe first, else FIFO head; address/data hold when idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we    <= 1'b0;
            rf_waddr <= '0;
            rf_wdata <= '0;
        end else if (pipe_wr) begin
            rf_we    <= 1'b1;
            rf_waddr <= pipe_waddr;
            rf_wdata <= pipe_wdata;
        end else if (pop && head_addr != '0) begin
            rf_we    <= 1'b1;
            rf_waddr <= head_addr;
            rf_wdata <= head_data;
        end else begin
            rf_we    <= 1'b0;
        end
    end
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// tb_regfile_writeback_arbiter: scoreboard bench for the writeback arbiter
module tb_regfile_writeback_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        pipe_we;
    logic [4:0]  pipe_waddr;
    logic [31:0] pipe_wdata;
    logic        ll_issue_valid;
    logic [4:0]  ll_issue_rd;
    logic        ll_valid;
    logic        ll_ready;
    logic [4:0]  ll_waddr;
    logic [31:0] ll_wdata;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic [4:0]  q_addr1, q_addr2;
    logic        q_busy1, q_busy2;
    logic        pipe_hold;

    int checks = 0;
    int errors = 0;
    logic [36:0] exp_q [$];

    regfile_writeback_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .pipe_we(pipe_we), .pipe_waddr(pipe_waddr), .pipe_wdata(pipe_wdata),
        .ll_issue_valid(ll_issue_valid), .ll_issue_rd(ll_issue_rd),
        .ll_valid(ll_valid), .ll_ready(ll_ready), .ll_waddr(ll_waddr), .ll_wdata(ll_wdata),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .q_addr1(q_addr1), .q_addr2(q_addr2), .q_busy1(q_busy1), .q_busy2(q_busy2),
        .pipe_hold(pipe_hold)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back({a, d});
    endtask

    task automatic pipe(input logic we, input logic [4:0] a, input logic [31:0] d);
        pipe_we = we;
        pipe_waddr = a;
        pipe_wdata = d;
        if (we && a != 0) expect_wr(a, d);
    endtask

    task automatic ll(input logic v, input logic [4:0] a, input logic [31:0] d);
        ll_valid = v;
        ll_waddr = a;
        ll_wdata = d;
    endtask

    // Monitor: every RF write must match the oldest expected write
    always @(negedge clk) begin
        if (rf_we) begin
            logic [36:0] e;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL rf_unexpected: got addr %0d data %h expected no write", rf_waddr, rf_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({rf_waddr, rf_wdata} !== e) begin
                    errors++;
                    $display("FAIL rf_write: got addr %0d data %h expected addr %0d data %h",
                             rf_waddr, rf_wdata, e[36:32], e[31:0]);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        pipe(0, 0, 0);
        ll(1, 5'd4, 32'h1111);
        ll_issue_valid = 0;
        ll_issue_rd = 0;
        q_addr1 = 7;
        q_addr2 = 3;
        step();
        step();
        chk("reset_rf_we", rf_we, 0);
        chk("reset_ll_ready", ll_ready, 1);
        chk("reset_busy1", q_busy1, 0);
        chk("reset_busy2", q_busy2, 0);
        chk("reset_hold", pipe_hold, 0);
        ll(0, 0, 0);
        rst_n = 1'b1;
        step();
        // basic pipe write
        pipe(1, 5, 32'hDEADBEEF);
        step();
        pipe(0, 0, 0);
        chk("pipe_we", rf_we, 1);
        chk("pipe_addr", rf_waddr, 5);
        chk("pipe_data", rf_wdata, 32'hDEADBEEF);
        // issue and return of rd=7
        ll_issue_valid = 1;
        ll_issue_rd = 7;
        step();
        ll_issue_valid = 0;
        chk("busy7_set", q_busy1, 1);
        ll(1, 7, 32'h1234);
        chk("ll_ready_empty", ll_ready, 1);
        step();
        ll(0, 0, 0);
        expect_wr(7, 32'h1234);
        chk("busy7_pending", q_busy1, 1);
        step();
        chk("ll_data", rf_wdata, 32'h1234);
        chk("busy7_clear", q_busy1, 0);
        // fill FIFO behind pipe writes, starvation builds
        pipe(1, 10, 32'h100);
        ll(1, 11, 32'hAAAA0001);
        step();
        ll(1, 12, 32'hAAAA0002);
        for (int k = 1; k <= 4; k++) begin
            pipe(1, 10, 32'h100 + k);
            step();
            if (k == 1) ll(1, 13, 32'hCCCC0003);
            chk("ll_ready_full", ll_ready, 0);
            chk("hold_build", pipe_hold, k == 4);
        end
        pipe(0, 0, 0);
        expect_wr(11, 32'hAAAA0001);
        step();
        chk("hold_release", pipe_hold, 0);
        chk("ll_ready_after_pop", ll_ready, 1);
        expect_wr(12, 32'hAAAA0002);
        step();
        ll(0, 0, 0);
        expect_wr(13, 32'hCCCC0003);
        step();
        step();
        chk("empty_ready", ll_ready, 1);
        // streaming push/pop at count=1 across pointer wrap
        for (int i = 0; i < 6; i++) begin
            ll(1, 5'(20 + i), 32'h5000 + i);
            if (i > 0) expect_wr(5'(20 + i - 1), 32'h5000 + i - 1);
            step();
            chk("stream_ready", ll_ready, 1);
        end
        ll(0, 0, 0);
        expect_wr(25, 32'h5005);
        step();
        step();
        // drain of rd=3 with simultaneous reissue of rd=3
        ll_issue_valid = 1;
        ll_issue_rd = 3;
        step();
        ll_issue_valid = 0;
        ll(1, 3, 32'h33);
        step();
        ll(0, 0, 0);
        ll_issue_valid = 1;
        ll_issue_rd = 3;
        expect_wr(3, 32'h33);
        step();
        ll_issue_valid = 0;
        chk("busy3_set_wins", q_busy2, 1);
        // zero-address result is discarded
        ll(1, 0, 32'hBAD);
        step();
        ll(0, 0, 0);
        step();
        chk("zero_rf_we", rf_we, 0);
        chk("zero_hold_addr", rf_waddr, 3);
        chk("zero_busy3", q_busy2, 1);
        // reset with FIFO full and busy bits set
        q_addr1 = 9;
        ll_issue_valid = 1;
        ll_issue_rd = 9;
        step();
        ll_issue_valid = 0;
        chk("busy9_set", q_busy1, 1);
        pipe(1, 1, 32'h77);
        ll(1, 9, 32'h99);
        step();
        pipe(1, 2, 32'h78);
        ll(1, 9, 32'h9A);
        step();
        pipe(0, 0, 0);
        ll(0, 0, 0);
        chk("full_ready", ll_ready, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_rf_we", rf_we, 0);
        chk("rst_ready", ll_ready, 1);
        chk("rst_busy9", q_busy1, 0);
        chk("rst_busy3", q_busy2, 0);
        chk("rst_hold", pipe_hold, 0);
        step();
        rst_n = 1'b1;
        step();
        step();
        chk("rst_no_drain", rf_we, 0);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
